// File: rtl/noc_axi4_req_deser.sv
// Collects a NoC request packet one flit at a time. Presents the header flits and the
// payload flits as one parallel word each on a valid/ready output, with a payload count.
module noc_axi4_req_deser #(
  parameter int NOC_DATA_WIDTH  = 64,
  parameter int HDR_FLITS       = 3,
  parameter int AXI4_DATA_WIDTH = 512,
  parameter bit SWAP_ENDIANESS  = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NOC_DATA_WIDTH-1:0]           flit_in,
  input  logic                                flit_in_val,
  output logic                                flit_in_rdy,
  output logic [HDR_FLITS*NOC_DATA_WIDTH-1:0] header_out,
  output logic [AXI4_DATA_WIDTH-1:0]          data_out,
  output logic [3:0]                          data_flits_out,
  output logic                                out_val,
  input  logic                                out_rdy,
  output logic                                err_overflow
);

  localparam int MAXW      = AXI4_DATA_WIDTH / NOC_DATA_WIDTH;
  localparam int HDR_IDX_W = (HDR_FLITS > 1) ? $clog2(HDR_FLITS) : 1;
  localparam int PAY_IDX_W = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int PAY_CNT_W = $clog2(MAXW + 1);
  // MSG_LENGTH position inside header flit 0
  localparam int LEN_LO    = 22;
  localparam int LEN_W     = 8;

  localparam logic [HDR_IDX_W-1:0] HDR_LAST = HDR_IDX_W'(HDR_FLITS - 1);
  localparam logic [PAY_CNT_W-1:0] PAY_MAX  = PAY_CNT_W'(MAXW);

  typedef enum logic [1:0] {ST_HDR, ST_DATA, ST_OUT} state_t;

  state_t                    state_reg;
  logic [HDR_IDX_W-1:0]      hdr_cnt_reg;
  logic [PAY_CNT_W-1:0]      pay_cnt_reg;
  logic [LEN_W-1:0]          rem_reg;
  logic                      out_val_reg;
  logic                      ovf_reg;
  logic [NOC_DATA_WIDTH-1:0] hdr_q [HDR_FLITS];
  logic [NOC_DATA_WIDTH-1:0] data_q [MAXW];

  logic                      flit_acc;
  logic [LEN_W-1:0]          rem_hdr_next;
  logic [NOC_DATA_WIDTH-1:0] pay_flit;

  function automatic logic [NOC_DATA_WIDTH-1:0] swap_bytes(input logic [NOC_DATA_WIDTH-1:0] f);
    logic [NOC_DATA_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < NOC_DATA_WIDTH / 8; b++) begin
      r[b*8 +: 8] = f[NOC_DATA_WIDTH-8-b*8 +: 8];
    end
    return r;
  endfunction

  assign flit_in_rdy = rst_n && (state_reg != ST_OUT);
  assign flit_acc    = flit_in_val && flit_in_rdy;

  always_comb begin
    rem_hdr_next = rem_reg - 1'b1;
    if (hdr_cnt_reg == '0) begin
      rem_hdr_next = flit_in[LEN_LO +: LEN_W];
    end
    pay_flit = SWAP_ENDIANESS ? swap_bytes(flit_in) : flit_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_HDR;
      hdr_cnt_reg <= '0;
      pay_cnt_reg <= '0;
      rem_reg     <= '0;
      out_val_reg <= 1'b0;
      ovf_reg     <= 1'b0;
      for (int i = 0; i < HDR_FLITS; i++) hdr_q[i] <= '0;
      for (int i = 0; i < MAXW; i++) data_q[i] <= '0;
    end else begin
      case (state_reg)
        ST_HDR: begin
          if (flit_acc) begin
            // Flit 0 starts a fresh packet, so stale slots from the previous one read 0
            if (hdr_cnt_reg == '0) begin
              for (int i = 0; i < HDR_FLITS; i++) hdr_q[i] <= (i == 0) ? flit_in : '0;
              for (int i = 0; i < MAXW; i++) data_q[i] <= '0;
              pay_cnt_reg <= '0;
              ovf_reg     <= 1'b0;
            end else begin
              hdr_q[hdr_cnt_reg] <= flit_in;
            end
            rem_reg <= rem_hdr_next;
            if (rem_hdr_next == '0) begin
              state_reg   <= ST_OUT;
              out_val_reg <= 1'b1;
              hdr_cnt_reg <= '0;
            end else if (hdr_cnt_reg == HDR_LAST) begin
              state_reg   <= ST_DATA;
              hdr_cnt_reg <= '0;
            end else begin
              hdr_cnt_reg <= hdr_cnt_reg + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (flit_acc) begin
            if (pay_cnt_reg < PAY_MAX) begin
              data_q[pay_cnt_reg[PAY_IDX_W-1:0]] <= pay_flit;
              pay_cnt_reg <= pay_cnt_reg + 1'b1;
            end else begin
              ovf_reg <= 1'b1;
            end
            rem_reg <= rem_reg - 1'b1;
            if (rem_reg == LEN_W'(1)) begin
              state_reg   <= ST_OUT;
              out_val_reg <= 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (out_rdy) begin
            out_val_reg <= 1'b0;
            ovf_reg     <= 1'b0;
            state_reg   <= ST_HDR;
          end
        end
        default: state_reg <= ST_HDR;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < HDR_FLITS; gi++) begin : g_hdr
      assign header_out[gi*NOC_DATA_WIDTH +: NOC_DATA_WIDTH] = hdr_q[gi];
    end
    for (gi = 0; gi < MAXW; gi++) begin : g_data
      assign data_out[gi*NOC_DATA_WIDTH +: NOC_DATA_WIDTH] = data_q[gi];
    end
  endgenerate

  assign data_flits_out = 4'(pay_cnt_reg);
  assign out_val        = out_val_reg;
  assign err_overflow   = ovf_reg;

endmodule

// File: tb/tb_noc_axi4_req_deser.sv
// Scoreboard bench: the driver pushes the expected reassembly of each packet, and a
// monitor compares it against the DUT whenever out_val is high.
module tb_noc_axi4_req_deser;
  localparam int NOC  = 64;
  localparam int HF   = 3;
  localparam int AXW  = 512;
  localparam int MAXW = AXW / NOC;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NOC-1:0]   flit_in = '0;
  logic             flit_in_val = 1'b0;
  logic             flit_in_rdy;
  logic [HF*NOC-1:0] header_out;
  logic [AXW-1:0]   data_out;
  logic [3:0]       data_flits_out;
  logic             out_val;
  logic             out_rdy = 1'b1;
  logic             err_overflow;

  noc_axi4_req_deser #(
    .NOC_DATA_WIDTH(NOC), .HDR_FLITS(HF), .AXI4_DATA_WIDTH(AXW), .SWAP_ENDIANESS(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_in_val(flit_in_val),
    .flit_in_rdy(flit_in_rdy), .header_out(header_out), .data_out(data_out),
    .data_flits_out(data_flits_out), .out_val(out_val), .out_rdy(out_rdy),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [HF*NOC-1:0] hdr;
    logic [AXW-1:0]    data;
    logic [3:0]        nflits;
    logic              ovf;
    int                hs_cycle;
  } exp_t;

  exp_t           exp_q[$];
  logic [NOC-1:0] pkt[$];
  int n_tests = 0;
  int n_fail  = 0;
  int hs_out_cycle = 0;
  int pkt_id = 0;

  task automatic check(input string name, input logic [AXW-1:0] act, input logic [AXW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [NOC-1:0] swap64(input logic [NOC-1:0] f);
    logic [NOC-1:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = f[56-b*8 +: 8];
    return r;
  endfunction

  // Header flit 0 with MSG_LENGTH in bits [29:22]
  function automatic logic [NOC-1:0] hdr0(input int len, input logic [NOC-1:0] seed);
    logic [NOC-1:0] h;
    h = seed;
    h[29:22] = 8'(len);
    return h;
  endfunction

  task automatic mk_pkt(input int len, input logic [31:0] seed);
    pkt.delete();
    pkt.push_back(hdr0(len, {seed, 32'hC0DE_0A15}));
    for (int i = 1; i <= len; i++) pkt.push_back({seed ^ 32'h5A5A_0000, 32'(i) * 32'h0101_0101});
  endtask

  task automatic send_pkt(input bit gaps, input int n_send, output int first_acc);
    exp_t e;
    int   npay, nsend;
    bit   acc;
    e.hdr = '0; e.data = '0;
    for (int i = 0; i < HF && i < pkt.size(); i++) e.hdr[i*NOC +: NOC] = pkt[i];
    npay = (pkt.size() > HF) ? pkt.size() - HF : 0;
    for (int k = 0; k < npay && k < MAXW; k++) e.data[k*NOC +: NOC] = swap64(pkt[HF+k]);
    e.nflits = 4'((npay > MAXW) ? MAXW : npay);
    e.ovf = (npay > MAXW);
    nsend = (n_send == 0) ? pkt.size() : n_send;
    first_acc = -1;
    for (int i = 0; i < nsend; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        flit_in_val = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      flit_in_val = 1'b1;
      flit_in = pkt[i];
      for (int w = 0; ; w++) begin
        @(negedge clk);
        acc = flit_in_rdy;
        @(posedge clk); #1;
        if (acc) break;
        if (w > 50) begin
          n_tests++; n_fail++;
          $display("FAIL flit_accept_timeout: got no acceptance, required acceptance within 50 cycles");
          break;
        end
      end
      if (i == 0) first_acc = cycle;
    end
    flit_in_val = 1'b0;
    e.hs_cycle = cycle;
    if (n_send == 0) begin
      exp_q.push_back(e);
      pkt_id++;
      $display("[TB] pkt %0d sent: %0d flits, expect nflits=%0d ovf=%0b", pkt_id, pkt.size(), e.nflits, e.ovf);
    end
  endtask

  // Monitor
  initial begin
    bit prev_val = 1'b0;
    bit prev_hs  = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_val = 1'b0;
        prev_hs  = 1'b0;
      end else begin
        if (prev_hs) check("out_val_pulse", AXW'(out_val), AXW'(0));
        if (out_val) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_val", AXW'(out_val), AXW'(0));
          end else begin
            e = exp_q[0];
            if (!prev_val) check("latency", AXW'(cycle), AXW'(e.hs_cycle));
            check("header_out", AXW'(header_out), AXW'(e.hdr));
            check("data_out", data_out, e.data);
            check("data_flits_out", AXW'(data_flits_out), AXW'(e.nflits));
            check("err_overflow", AXW'(err_overflow), AXW'(e.ovf));
            check("rdy_in_out", AXW'(flit_in_rdy), AXW'(0));
            if (out_rdy) begin
              void'(exp_q.pop_front());
              hs_out_cycle = cycle + 1;
              $display("[TB] packet delivered at cycle %0d nflits=%0d ovf=%0b", cycle + 1, data_flits_out, err_overflow);
            end
          end
        end
        prev_val = out_val;
        prev_hs  = out_val && out_rdy;
      end
    end
  end

  initial begin
    int fa, fa2;
    logic [NOC-1:0] nc_pay;
    logic [AXW-1:0] nc_exp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", AXW'(flit_in_rdy), AXW'(0));
    check("rst_out_val", AXW'(out_val), AXW'(0));
    check("rst_err", AXW'(err_overflow), AXW'(0));
    check("rst_nflits", AXW'(data_flits_out), AXW'(0));
    check("rst_header", AXW'(header_out), AXW'(0));
    check("rst_data", data_out, AXW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    mk_pkt(10, 32'h0000_A001); send_pkt(1'b0, 0, fa);   // store, 8 payload
    mk_pkt(2,  32'h0000_B002); send_pkt(1'b0, 0, fa);   // load, header only
    // NC store with a single payload flit checked against a hand-swapped constant
    nc_pay = 64'h0011_2233_4455_6677;
    mk_pkt(3, 32'h0000_C003); pkt[3] = nc_pay; send_pkt(1'b0, 0, fa);
    nc_exp = '0; nc_exp[63:0] = 64'h7766_5544_3322_1100;
    check("nc_model_swap", AXW'(swap64(nc_pay)), nc_exp);
    mk_pkt(12, 32'h0000_D004); send_pkt(1'b0, 0, fa);   // oversize
    mk_pkt(4,  32'h0000_E005); send_pkt(1'b0, 0, fa);   // ovf must clear
    mk_pkt(0,  32'h0000_F006); send_pkt(1'b0, 0, fa);   // len=0
    mk_pkt(1,  32'h0000_F007); send_pkt(1'b0, 0, fa);   // short header

    // Backpressure with flit gaps, then a back-to-back packet
    repeat (3) begin @(posedge clk); #1; end
    out_rdy = 1'b0;
    fork
      begin
        mk_pkt(10, 32'h0000_1108); send_pkt(1'b1, 0, fa);
        mk_pkt(2,  32'h0000_2209); send_pkt(1'b0, 0, fa2);
        check("b2b_accept", AXW'(fa2), AXW'(hs_out_cycle + 1));
      end
      begin
        for (int w = 0; w < 300 && !out_val; w++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1 out_rdy = 1'b1;
      end
    join
    mk_pkt(11, 32'h0000_330A); send_pkt(1'b1, 0, fa);

    // Reset mid-packet
    repeat (3) begin @(posedge clk); #1; end
    mk_pkt(10, 32'h0000_440B); send_pkt(1'b0, 4, fa);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("midrst_rdy", AXW'(flit_in_rdy), AXW'(0));
    check("midrst_out_val", AXW'(out_val), AXW'(0));
    check("midrst_data", data_out, AXW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    mk_pkt(2, 32'h0000_550C); send_pkt(1'b0, 0, fa);

    for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("drain", AXW'(exp_q.size()), AXW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
